polyvecl_addsub_stream: RTL
===========================

// Module: polyvecl_addsub_stream
// PURPOSE
//  Streaming, parametrised successor to the combinational polynomial-vector adder.
//  Adds or subtracts two length-L polynomial vectors, LANES coefficients per beat, over valid/ready streams.
//  Optional single-step reduction mod Q. Sits between the NTT/poly stores and the signing/verify datapath.
//  Replaces the wide flat L*N*CW buses with a beat-serial interface.
// PARAMETERS
//  L      5        polynomials per vector
//  N      256      coefficients per polynomial; N % LANES == 0
//  CW     32       coefficient width, signed two's complement
//  LANES  8        coefficients per beat
//  Q      8380417  modulus used when reduce=1
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous reset, active-high
//  start      in   1           pulse: begin one vector operation; sampled only in IDLE
//  mode_sub   in   1           sampled with start: 0 = a+b, 1 = a-b
//  reduce     in   1           sampled with start: 1 = result mapped to [0,Q)
//  in_valid   in   1           a_data/b_data beat valid
//  in_ready   out  1           beat accepted when in_valid & in_ready
//  a_data     in   LANES*CW    lane k = bits [CW*k +: CW]; coefficient index = beat*LANES + k
//  b_data     in   LANES*CW    same packing as a_data
//  out_valid  out  1           result beat valid
//  out_ready  in   1           downstream accepts the result beat
//  out_data   out  LANES*CW    result, same packing as a_data
//  out_plast  out  1           last beat of the current polynomial
//  out_vlast  out  1           last beat of the whole vector (implies out_plast)
//  busy       out  1           high from the cycle after start until done
//  done       out  1           one-cycle pulse after the final result beat is accepted
// BEHAVIOUR
//  Reset (async): FSM=IDLE, counters=0, pipeline empty, all outputs 0 (in_ready=0, out_valid=0).
//  FSM: IDLE --start--> RUN --last input beat accepted--> DRAIN --final output accepted--> DONE --> IDLE.
//   - DONE lasts 1 cycle; done=1 only there. busy=1 in RUN, DRAIN, DONE.
//   - start outside IDLE is ignored; mode_sub/reduce are latched at start and held for the whole vector.
//  Counters: beat_cnt 0..N/LANES-1 and poly_cnt 0..L-1.
//   - Both advance on input accept; beat_cnt wraps to 0 and poly_cnt increments.
//   - Last input beat = (beat_cnt==N/LANES-1 && poly_cnt==L-1).
//   - out_plast and out_vlast are carried through the pipeline alongside the data.
//  Pipeline: 2 register stages, fixed latency 2 cycles input-accept -> out_valid when not stalled.
//   - Stage advance enable: adv = !out_valid | out_ready; the whole pipe freezes when !adv.
//   - in_ready = (state==RUN) & adv. No combinational path from in_valid to in_ready.
//   - Bubbles may be present; full throughput is 1 beat/cycle with out_ready held high.
//  Arithmetic, per lane, performed independently:
//   - Stage 1 computes s = a +/- b in CW+1 bits.
//   - reduce=0: result = s[CW-1:0] (two's-complement wrap).
//   - reduce=1, add: if s>=Q then s-Q else s.
//   - reduce=1, sub: if s<0 then s+Q else s.
//   - reduce=1 presumes inputs in [0,Q); exactly one correction is applied, with no range check.
//  Boundaries:
//   - out_ready=0 holds out_data/out_valid/out_*last stable until accepted.
//   - in_valid may drop at any time; counters only move on an accepted beat.
//   - rst mid-operation aborts: pipeline is flushed, no done pulse, IDLE.
//   - start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
//   - L=1 and LANES=N (single beat per poly) must both work.
// TESTING
//  1. Defaults, reduce=0, add, a=coef idx, b=1000, out_ready=1 -> 160 beats, lane k = idx+1000; done one cycle after beat 159.
//  2. reduce=1 add, a=Q-1, b=1 -> all 0; a=Q-2, b=1 -> Q-1. reduce=1 sub, a=0, b=1 -> Q-1; a=5, b=3 -> 2.
//  3. reduce=0 sub, a=0x80000000, b=1 -> 0x7FFFFFFF (wrap); a=-3, b=4 -> 0xFFFFFFF9.
//  4. Random out_ready (50%) and in_valid gaps -> no beat lost or duplicated; out_plast on beats 31,63,..; out_vlast only on beat 159.
//  5. Assert rst at beat 70 -> out_valid=0, busy=0 next cycle, no done; a fresh start then runs a clean full vector.
//  6. start pulsed while busy with mode_sub toggled -> ignored; results keep the original mode; busy/done timing unchanged.

Source files
------------

// File: rtl/polyvecl_addsub_stream_if.sv
// rtl/polyvecl_addsub_stream_if.sv - input and result beat streams of the polynomial-vector add/sub
interface polyvecl_addsub_stream_if #(
   parameter int LANES = 8,
   parameter int CW    = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [LANES*CW-1:0] a_data;
   logic [LANES*CW-1:0] b_data;
   logic                out_valid;
   logic                out_ready;
   logic [LANES*CW-1:0] out_data;
   logic                out_plast;
   logic                out_vlast;

   modport master (
      output in_valid, a_data, b_data, out_ready,
      input  in_ready, out_valid, out_data, out_plast, out_vlast
   );

   modport slave (
      input  in_valid, a_data, b_data, out_ready,
      output in_ready, out_valid, out_data, out_plast, out_vlast
   );
endinterface

// File: rtl/polyvecl_addsub_stream.sv
// rtl/polyvecl_addsub_stream.sv - beat-serial add/sub of two polynomial vectors with optional mod-Q fix-up
module polyvecl_addsub_stream #(
   parameter int L     = 5,
   parameter int N     = 256,
   parameter int CW    = 32,
   parameter int LANES = 8,
   parameter int Q     = 8380417
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    mode_sub,
   input  logic                    reduce,
   polyvecl_addsub_stream_if.slave strm,
   output logic                    busy,
   output logic                    done
);
   localparam int BEATS = N / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PW    = (L > 1) ? $clog2(L) : 1;
   localparam logic signed [CW:0] QS = (CW+1)'(Q);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                  state;
   state_t                  state_nx;
   logic                    mode_r;
   logic                    reduce_r;
   logic [BW-1:0]           beat_cnt;
   logic [PW-1:0]           poly_cnt;
   logic                    adv;
   logic                    accept;
   logic                    beat_last;
   logic                    poly_last;
   logic                    vec_last;
   logic                    v1;
   logic                    plast1;
   logic                    vlast1;
   logic [LANES-1:0][CW:0]   s1;
   logic [LANES-1:0][CW:0]   sum_d;
   logic [LANES-1:0][CW-1:0] res_d;

   // Whole pipe moves together; it only freezes when a result beat is waiting downstream.
   assign adv       = !strm.out_valid | strm.out_ready;
   assign accept    = strm.in_valid & strm.in_ready;
   assign beat_last = (beat_cnt == BW'(BEATS - 1));
   assign poly_last = (poly_cnt == PW'(L - 1));
   assign vec_last  = beat_last & poly_last;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state: leave RUN on the last input beat, leave DRAIN on the last result beat.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_RUN;
         S_RUN:   if (accept && vec_last) state_nx = S_DRAIN;
         S_DRAIN: if (strm.out_valid && strm.out_ready && strm.out_vlast) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // FSM outputs; in_ready depends only on state and the downstream side.
   always_comb begin
      busy          = (state != S_IDLE);
      done          = (state == S_DONE);
      strm.in_ready = (state == S_RUN) & adv;
   end

   // Latch the operation mode at start and walk beat/poly position on every accepted beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_r   <= 1'b0;
         reduce_r <= 1'b0;
         beat_cnt <= '0;
         poly_cnt <= '0;
      end else if (state == S_IDLE && start) begin
         mode_r   <= mode_sub;
         reduce_r <= reduce;
         beat_cnt <= '0;
         poly_cnt <= '0;
      end else if (accept) begin
         if (beat_last) begin
            beat_cnt <= '0;
            poly_cnt <= poly_last ? '0 : poly_cnt + PW'(1);
         end else begin
            beat_cnt <= beat_cnt + BW'(1);
         end
      end
   end

   // Stage-1 arithmetic: sign-extended add or subtract per lane, keeping the carry bit.
   always_comb begin
      sum_d = '0;
      for (int k = 0; k < LANES; k++) begin
         if (mode_r)
            sum_d[k] = {strm.a_data[CW*k+CW-1], strm.a_data[CW*k +: CW]}
                     - {strm.b_data[CW*k+CW-1], strm.b_data[CW*k +: CW]};
         else
            sum_d[k] = {strm.a_data[CW*k+CW-1], strm.a_data[CW*k +: CW]}
                     + {strm.b_data[CW*k+CW-1], strm.b_data[CW*k +: CW]};
      end
   end

   // Stage-2 fix-up: a single conditional +/-Q brings a reduced-range sum back into [0,Q).
   always_comb begin
      res_d = '0;
      for (int k = 0; k < LANES; k++) begin
         if (reduce_r && !mode_r && ($signed(s1[k]) >= QS))
            res_d[k] = CW'(s1[k] - QS);
         else if (reduce_r && mode_r && s1[k][CW])
            res_d[k] = CW'(s1[k] + QS);
         else
            res_d[k] = s1[k][CW-1:0];
      end
   end

   // Two-stage pipe with the polynomial/vector end markers travelling next to the data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1             <= 1'b0;
         s1             <= '0;
         plast1         <= 1'b0;
         vlast1         <= 1'b0;
         strm.out_valid <= 1'b0;
         strm.out_data  <= '0;
         strm.out_plast <= 1'b0;
         strm.out_vlast <= 1'b0;
      end else if (adv) begin
         v1             <= accept;
         s1             <= sum_d;
         plast1         <= accept & beat_last;
         vlast1         <= accept & vec_last;
         strm.out_valid <= v1;
         strm.out_data  <= res_d;
         strm.out_plast <= plast1;
         strm.out_vlast <= vlast1;
      end
   end
endmodule
